// File: rtl/mini_core_accel_cr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mini_core_accel_cr_ctrl
// Purpose  : Control-register bank between the mini_core data-memory port and
//            an NUM_CH-channel accelerator farm. Each channel owns a
//            start/busy/done handshake FSM, captures its result on completion
//            and reports sticky, clear-on-read status.
// Ports    : Clk         - clock, all state updates on the rising edge
//            Rst         - synchronous active-low reset
//            data        - core write data (32)
//            address     - core byte address (32)
//            wren/rden   - core write / read strobes
//            q           - registered read data, holds while rden is low
//            acc_operand - per-channel {multiplicand, multiplier}
//            acc_start   - per-channel one-cycle start pulse (registered)
//            acc_result  - per-channel result, valid with acc_done
//            acc_done    - per-channel completion pulse
//            irq         - registered OR of all channel done bits
// Option   : MINI_CORE_ACCEL_CR_TIMEOUT_EN adds a per-channel watchdog that
//            forces DONE with RESULT=0 and STATUS.err after TIMEOUT_CYC
//            busy cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mini_core_accel_cr_ctrl #(
    parameter int          NUM_CH      = 8,
    parameter int          DATA_W      = 8,
    parameter logic [31:0] CR_BASE     = 32'h00FE_0000,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [31:0]                data,
    input  logic [31:0]                address,
    input  logic                       wren,
    input  logic                       rden,
    output logic [31:0]                q,
    output logic [NUM_CH*2*DATA_W-1:0] acc_operand,
    output logic [NUM_CH-1:0]          acc_start,
    input  logic [NUM_CH*2*DATA_W-1:0] acc_result,
    input  logic [NUM_CH-1:0]          acc_done,
    output logic                       irq
);

    localparam int          c_OP_W    = 2 * DATA_W;
    localparam logic [31:0] c_SUM_OFF = 32'(NUM_CH * 16);
    localparam logic [1:0]  c_S_IDLE  = 2'd0;
    localparam logic [1:0]  c_S_BUSY  = 2'd1;
    localparam logic [1:0]  c_S_DONE  = 2'd2;

    // Address decode: offset within the window, word select inside a channel.
    logic [31:0]              w_off;
    logic                     w_in_ch;
    logic                     w_is_sum;
    logic [1:0]               w_word;
    logic [NUM_CH-1:0]        w_sel;
    logic [NUM_CH-1:0]        w_go;
    logic [NUM_CH-1:0]        w_done_vec;
    logic [NUM_CH-1:0]        w_done_nxt;
    logic [NUM_CH-1:0][31:0]  w_rd_ch;
    logic [31:0]              w_rdata;
    logic                     w_unused;

    assign w_off    = address - CR_BASE;
    // Only word-aligned addresses map to registers.
    assign w_in_ch  = (w_off < c_SUM_OFF) && (w_off[1:0] == 2'b00);
    assign w_is_sum = (w_off == c_SUM_OFF);
    assign w_word   = w_off[3:2];
    assign w_unused = ^{data, 32'(TIMEOUT_CYC)};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [3:0] c_IDX = 4'(c);

        logic              w_wr_op;
        logic              w_wr_ctrl;
        logic              w_rd_stat;
        logic              w_expire;
        logic [1:0]        r_state;
        logic [1:0]        w_state_nxt;
        logic              w_capture;
        logic              w_start;
        logic              w_ovr_set;
        logic              w_tmo;
        logic [c_OP_W-1:0] r_op;
        logic [c_OP_W-1:0] r_res;
        logic              r_ovr;
        logic              r_err;

        assign w_sel[c]  = w_in_ch && (w_off[7:4] == c_IDX);
        assign w_wr_op   = wren && w_sel[c] && (w_word == 2'd0);
        assign w_wr_ctrl = wren && w_sel[c] && (w_word == 2'd1);
        assign w_rd_stat = rden && w_sel[c] && (w_word == 2'd2);

`ifdef MINI_CORE_ACCEL_CR_TIMEOUT_EN
        localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge Clk) begin
            if (!Rst) begin
                r_cnt <= '0;
            end else if (w_start) begin
                r_cnt <= '0;
            end else if (r_state == c_S_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        // Expires on the busy cycle whose increment would reach TIMEOUT_CYC.
        assign w_expire = (r_state == c_S_BUSY) &&
                          (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`else
        assign w_expire = 1'b0;
`endif

        always_comb begin
            w_state_nxt = r_state;
            w_capture   = 1'b0;
            w_start     = 1'b0;
            w_ovr_set   = 1'b0;
            w_tmo       = 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_wr_ctrl && data[0]) begin
                        w_state_nxt = c_S_BUSY;
                        w_start     = 1'b1;
                    end
                end
                c_S_BUSY: begin
                    // Completion beats both abort and watchdog expiry.
                    if (acc_done[c]) begin
                        w_state_nxt = c_S_DONE;
                        w_capture   = 1'b1;
                    end else if (w_wr_ctrl && data[1]) begin
                        w_state_nxt = c_S_IDLE;
                    end else if (w_expire) begin
                        w_state_nxt = c_S_DONE;
                        w_tmo       = 1'b1;
                    end
                    if ((w_wr_ctrl && data[0]) || w_wr_op) begin
                        w_ovr_set = 1'b1;
                    end
                end
                c_S_DONE: begin
                    // A restart takes precedence over the clearing status read.
                    if (w_wr_ctrl && data[0]) begin
                        w_state_nxt = c_S_BUSY;
                        w_start     = 1'b1;
                    end else if (w_rd_stat) begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
                default: w_state_nxt = c_S_IDLE;
            endcase
        end

        always_ff @(posedge Clk) begin
            if (!Rst) begin
                r_state <= c_S_IDLE;
                r_op    <= '0;
                r_res   <= '0;
                r_ovr   <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (w_wr_op && (r_state != c_S_BUSY)) begin
                    r_op <= data[c_OP_W-1:0];
                end
                if (w_capture) begin
                    r_res <= acc_result[c*c_OP_W +: c_OP_W];
                end else if (w_tmo) begin
                    r_res <= '0;
                end
                if (w_ovr_set) begin
                    r_ovr <= 1'b1;
                end else if (w_rd_stat) begin
                    r_ovr <= 1'b0;
                end
                if (w_tmo) begin
                    r_err <= 1'b1;
                end else if (w_rd_stat) begin
                    r_err <= 1'b0;
                end
            end
        end

        assign w_go[c]       = w_start;
        assign w_done_vec[c] = (r_state == c_S_DONE);
        assign w_done_nxt[c] = (w_state_nxt == c_S_DONE);
        assign acc_operand[c*c_OP_W +: c_OP_W] = r_op;

        // Read view reflects pre-update state for same-cycle writes/events.
        assign w_rd_ch[c] =
            (w_word == 2'd0) ? 32'(r_op) :
            (w_word == 2'd2) ? {28'd0, r_err, r_ovr,
                                (r_state == c_S_DONE), (r_state == c_S_BUSY)} :
            (w_word == 2'd3) ? 32'(r_res) : 32'd0;
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_is_sum) begin
            w_rdata = 32'(w_done_vec);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel[c]) begin
                w_rdata = w_rdata | w_rd_ch[c];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            q         <= 32'd0;
            acc_start <= '0;
            irq       <= 1'b0;
        end else begin
            if (rden) begin
                q <= w_rdata;
            end
            acc_start <= w_go;
            irq       <= |w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mini_core_accel_cr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mini_core_accel_cr_ctrl
// Purpose  : Self-checking bench for mini_core_accel_cr_ctrl (8 channels,
//            8-bit operands). Table of directed cycle vectors plus hand-written
//            sequences for operands, reset-while-busy and the watchdog option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mini_core_accel_cr_ctrl;

    localparam logic [31:0] c_BASE = 32'h00FE_0000;
`ifdef MINI_CORE_ACCEL_CR_TIMEOUT_EN
    localparam int c_TMO = 16;
`else
    localparam int c_TMO = 1024;
`endif

    logic         Clk;
    logic         Rst;
    logic [31:0]  data;
    logic [31:0]  address;
    logic         wren;
    logic         rden;
    logic [31:0]  q;
    logic [127:0] acc_operand;
    logic [7:0]   acc_start;
    logic [127:0] acc_result;
    logic [7:0]   acc_done;
    logic         irq;

    int n_cmp  = 0;
    int n_fail = 0;

    mini_core_accel_cr_ctrl #(
        .NUM_CH      (8),
        .DATA_W      (8),
        .CR_BASE     (c_BASE),
        .TIMEOUT_CYC (c_TMO)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .data        (data),
        .address     (address),
        .wren        (wren),
        .rden        (rden),
        .q           (q),
        .acc_operand (acc_operand),
        .acc_start   (acc_start),
        .acc_result  (acc_result),
        .acc_done    (acc_done),
        .irq         (irq)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [7:0]  dn;
        logic [15:0] res;
        logic [31:0] eq;
        logic [7:0]  es;
        logic        ei;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] ra(input int c, input int w);
        return c_BASE + 32'(c * 16 + w * 4);
    endfunction

    function automatic vec_t mk(input logic wr, input logic rd,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [7:0] dn, input logic [15:0] res,
                                input logic [31:0] eq, input logic [7:0] es,
                                input logic ei);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wd = wd; v.dn = dn; v.res = res;
        v.eq = eq; v.es = es; v.ei = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic apply(input vec_t v);
        wren       = v.wr;
        rden       = v.rd;
        address    = v.addr;
        data       = v.wd;
        acc_done   = v.dn;
        acc_result = {8{v.res}};
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        wren = 1'b0; rden = 1'b0; address = 32'd0; data = 32'd0;
        acc_done = 8'd0; acc_result = '0;
    endtask

    initial begin
        //        wr    rd    addr             wdata     done   res       q        start  irq
        vt.push_back(mk(1'b0, 1'b1, ra(0,2),       32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 0
        vt.push_back(mk(1'b1, 1'b0, ra(2,0),       32'h0305, 8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 1
        vt.push_back(mk(1'b1, 1'b0, ra(2,1),       32'h1,    8'h00, 16'h0000, 32'h0,    8'h04, 1'b0)); // 2
        vt.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 3
        vt.push_back(mk(1'b0, 1'b1, ra(2,2),       32'h0,    8'h00, 16'h0000, 32'h1,    8'h00, 1'b0)); // 4
        vt.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,    8'h04, 16'h000F, 32'h1,    8'h00, 1'b1)); // 5
        vt.push_back(mk(1'b0, 1'b1, ra(2,3),       32'h0,    8'h00, 16'h0000, 32'hF,    8'h00, 1'b1)); // 6
        vt.push_back(mk(1'b0, 1'b1, ra(2,2),       32'h0,    8'h00, 16'h0000, 32'h2,    8'h00, 1'b0)); // 7
        vt.push_back(mk(1'b0, 1'b1, ra(2,2),       32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 8
        vt.push_back(mk(1'b1, 1'b0, ra(5,0),       32'h1234, 8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 9
        vt.push_back(mk(1'b1, 1'b0, ra(5,1),       32'h1,    8'h00, 16'h0000, 32'h0,    8'h20, 1'b0)); // 10
        vt.push_back(mk(1'b1, 1'b0, ra(5,0),       32'hFFFF, 8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 11
        vt.push_back(mk(1'b0, 1'b1, ra(5,2),       32'h0,    8'h00, 16'h0000, 32'h5,    8'h00, 1'b0)); // 12
        vt.push_back(mk(1'b0, 1'b1, ra(5,0),       32'h0,    8'h00, 16'h0000, 32'h1234, 8'h00, 1'b0)); // 13
        vt.push_back(mk(1'b0, 1'b1, ra(5,2),       32'h0,    8'h00, 16'h0000, 32'h1,    8'h00, 1'b0)); // 14
        vt.push_back(mk(1'b1, 1'b0, ra(5,1),       32'h1,    8'h00, 16'h0000, 32'h1,    8'h00, 1'b0)); // 15
        vt.push_back(mk(1'b0, 1'b1, ra(5,2),       32'h0,    8'h00, 16'h0000, 32'h5,    8'h00, 1'b0)); // 16
        vt.push_back(mk(1'b1, 1'b0, ra(5,1),       32'h2,    8'h00, 16'h0000, 32'h5,    8'h00, 1'b0)); // 17
        vt.push_back(mk(1'b0, 1'b1, ra(5,2),       32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 18
        vt.push_back(mk(1'b1, 1'b0, ra(1,1),       32'h1,    8'h00, 16'h0000, 32'h0,    8'h02, 1'b0)); // 19
        vt.push_back(mk(1'b1, 1'b0, ra(1,1),       32'h2,    8'h02, 16'h00AB, 32'h0,    8'h00, 1'b1)); // 20
        vt.push_back(mk(1'b0, 1'b1, ra(1,3),       32'h0,    8'h00, 16'h0000, 32'hAB,   8'h00, 1'b1)); // 21
        vt.push_back(mk(1'b0, 1'b1, ra(1,2),       32'h0,    8'h00, 16'h0000, 32'h2,    8'h00, 1'b0)); // 22
        vt.push_back(mk(1'b1, 1'b0, ra(1,1),       32'h1,    8'h00, 16'h0000, 32'h2,    8'h02, 1'b0)); // 23
        vt.push_back(mk(1'b1, 1'b0, ra(1,1),       32'h2,    8'h00, 16'h0000, 32'h2,    8'h00, 1'b0)); // 24
        vt.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,    8'h02, 16'h00CD, 32'h2,    8'h00, 1'b0)); // 25
        vt.push_back(mk(1'b0, 1'b1, ra(1,2),       32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 26
        vt.push_back(mk(1'b0, 1'b1, ra(1,3),       32'h0,    8'h00, 16'h0000, 32'hAB,   8'h00, 1'b0)); // 27
        vt.push_back(mk(1'b1, 1'b0, ra(0,1),       32'h1,    8'h00, 16'h0000, 32'hAB,   8'h01, 1'b0)); // 28
        vt.push_back(mk(1'b1, 1'b0, ra(7,1),       32'h1,    8'h00, 16'h0000, 32'hAB,   8'h80, 1'b0)); // 29
        vt.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,    8'h81, 16'h0042, 32'hAB,   8'h00, 1'b1)); // 30
        vt.push_back(mk(1'b0, 1'b1, c_BASE+32'h80, 32'h0,    8'h00, 16'h0000, 32'h81,   8'h00, 1'b1)); // 31
        vt.push_back(mk(1'b0, 1'b1, c_BASE+32'h80, 32'h0,    8'h00, 16'h0000, 32'h81,   8'h00, 1'b1)); // 32
        vt.push_back(mk(1'b0, 1'b1, c_BASE+32'h84, 32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b1)); // 33
        vt.push_back(mk(1'b0, 1'b1, ra(0,2),       32'h0,    8'h00, 16'h0000, 32'h2,    8'h00, 1'b1)); // 34
        vt.push_back(mk(1'b0, 1'b1, ra(7,2),       32'h0,    8'h00, 16'h0000, 32'h2,    8'h00, 1'b0)); // 35
        vt.push_back(mk(1'b0, 1'b1, c_BASE+32'h80, 32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 36
        vt.push_back(mk(1'b1, 1'b0, ra(3,1),       32'h1,    8'h00, 16'h0000, 32'h0,    8'h08, 1'b0)); // 37
        vt.push_back(mk(1'b0, 1'b1, ra(3,2),       32'h0,    8'h08, 16'h0077, 32'h1,    8'h00, 1'b1)); // 38
        vt.push_back(mk(1'b0, 1'b1, ra(3,2),       32'h0,    8'h00, 16'h0000, 32'h2,    8'h00, 1'b0)); // 39
        vt.push_back(mk(1'b1, 1'b1, ra(4,0),       32'h5A5A, 8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 40
        vt.push_back(mk(1'b0, 1'b1, ra(4,0),       32'h0,    8'h00, 16'h0000, 32'h5A5A, 8'h00, 1'b0)); // 41
        vt.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,    8'h00, 16'h0000, 32'h5A5A, 8'h00, 1'b0)); // 42
        vt.push_back(mk(1'b0, 1'b1, c_BASE+32'h41, 32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 43
        vt.push_back(mk(1'b0, 1'b1, 32'h0,         32'h0,    8'h00, 16'h0000, 32'h0,    8'h00, 1'b0)); // 44

        // Reset state.
        idle_inputs();
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_q", 128'(q), 128'h0);
        chk("rst_irq", 128'(irq), 128'h0);
        chk("rst_start", 128'(acc_start), 128'h0);
        chk("rst_operand", acc_operand, 128'h0);
        Rst = 1'b1;

        foreach (vt[i]) begin
            apply(vt[i]);
            chk($sformatf("v%0d_q", i), 128'(q), 128'(vt[i].eq));
            chk($sformatf("v%0d_start", i), 128'(acc_start), 128'(vt[i].es));
            chk($sformatf("v%0d_irq", i), 128'(irq), 128'(vt[i].ei));
        end
        idle_inputs();

        // Operand outputs: accepted writes visible, rejected busy write absent.
        chk("op_ch2", 128'(acc_operand[2*16 +: 16]), 128'h0305);
        chk("op_ch5", 128'(acc_operand[5*16 +: 16]), 128'h1234);
        chk("op_ch4", 128'(acc_operand[4*16 +: 16]), 128'h5A5A);

`ifdef MINI_CORE_ACCEL_CR_TIMEOUT_EN
        // Watchdog: 16 busy cycles without completion force DONE with err.
        apply(mk(1'b1, 1'b0, ra(3,1), 32'h1, 8'h00, 16'h0, 32'h0, 8'h00, 1'b0));
        chk("tmo_start", 128'(acc_start), 128'h08);
        idle_inputs();
        repeat (16) @(posedge Clk);
        #1;
        apply(mk(1'b0, 1'b1, ra(3,2), 32'h0, 8'h00, 16'h0, 32'h0, 8'h00, 1'b0));
        chk("tmo_status", 128'(q), 128'hA);
        apply(mk(1'b0, 1'b1, ra(3,3), 32'h0, 8'h00, 16'h0, 32'h0, 8'h00, 1'b0));
        chk("tmo_result", 128'(q), 128'h0);
        apply(mk(1'b0, 1'b1, ra(3,2), 32'h0, 8'h00, 16'h0, 32'h0, 8'h00, 1'b0));
        chk("tmo_status_clr", 128'(q), 128'h0);
        idle_inputs();
`endif

        // Reset while busy: silent abort, completions during/after reset ignored.
        apply(mk(1'b1, 1'b0, ra(6,1), 32'h1, 8'h00, 16'h0, 32'h0, 8'h00, 1'b0));
        chk("rb_start", 128'(acc_start), 128'h40);
        idle_inputs();
        Rst      = 1'b0;
        acc_done = 8'h40;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        apply(mk(1'b0, 1'b0, 32'h0, 32'h0, 8'h40, 16'h0099, 32'h0, 8'h00, 1'b0));
        chk("rb_irq_late", 128'(irq), 128'h0);
        apply(mk(1'b0, 1'b1, ra(6,2), 32'h0, 8'h00, 16'h0, 32'h0, 8'h00, 1'b0));
        chk("rb_status", 128'(q), 128'h0);
        apply(mk(1'b0, 1'b1, ra(6,3), 32'h0, 8'h00, 16'h0, 32'h0, 8'h00, 1'b0));
        chk("rb_result", 128'(q), 128'h0);
        chk("rb_operand", acc_operand, 128'h0);
        chk("rb_irq", 128'(irq), 128'h0);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
